// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand side (in_*) and result side (out_*).
interface logic_unit_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic [15:0]      op_count;

    modport master (
        output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, ones, op_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, ones, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with optional accumulator, feeding a 2-entry result FIFO
// whose entries carry their own zero/ones flags.
module logic_unit_pipe #(
    parameter int WIDTH  = 16,
    parameter bit ACC_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    logic_unit_pipe_if.slave bus
);
    typedef struct packed {
        logic             zero;
        logic             ones;
        logic [WIDTH-1:0] res;
    } entry_t;

    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           newEntry;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [15:0]      opCount_q, opCount_d;
    logic [WIDTH-1:0] aEff;
    logic [WIDTH-1:0] result;
    logic             inReady;
    logic             outValid;
    logic             accept;
    logic             drain;

    assign inReady  = (count_q != 2'd2);
    assign outValid = (count_q != 2'd0);
    assign accept   = bus.in_valid & inReady;
    assign drain    = bus.out_ready & outValid;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.y         = head_q.res;
    assign bus.zero      = head_q.zero;
    assign bus.ones      = head_q.ones;
    assign bus.op_count  = opCount_q;

    // A clear in the same cycle as an accumulate op makes that op see a zero accumulator.
    always_comb begin
        aEff = bus.a;
        if (ACC_EN && bus.acc_mode) begin
            aEff = bus.acc_clr ? '0 : acc_q;
        end
        case (bus.op)
            3'd0:    result = ~(aEff & bus.b);
            3'd1:    result = ~aEff;
            3'd2:    result = aEff & bus.b;
            3'd3:    result = aEff | bus.b;
            3'd4:    result = aEff ^ bus.b;
            3'd5:    result = ~(aEff | bus.b);
            3'd6:    result = ~(aEff ^ bus.b);
            default: result = bus.b;
        endcase
        newEntry.zero = (result == '0);
        newEntry.ones = &result;
        newEntry.res  = result;
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + {1'b0, accept} - {1'b0, drain};
        opCount_d = opCount_q + 16'(accept);
        acc_d     = acc_q;
        if (drain && count_q == 2'd2) begin
            head_d = tail_q;
        end
        // New entry lands in the head slot whenever the FIFO is, or is about to be, empty.
        if (accept) begin
            if (count_q == 2'd0 || drain) begin
                head_d = newEntry;
            end else begin
                tail_d = newEntry;
            end
        end
        if (!ACC_EN || bus.acc_clr) begin
            acc_d = '0;
        end else if (accept && bus.acc_mode) begin
            acc_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            acc_q     <= '0;
            opCount_q <= 16'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opCount_q <= opCount_d;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised self-checking bench for logic_unit_pipe against a queue-based reference model.
`timescale 1ns/1ps
module tb_logic_unit_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(W)) lu ();
    logic_unit_pipe #(.WIDTH(W), .ACC_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(lu));

    int checks = 0;
    int errors = 0;

    logic [W-1:0] modelQ[$];
    logic [W-1:0] modelAcc = '0;
    logic [15:0]  modelOpCount = 16'd0;

    function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] z);
        case (op)
            3'd0:    return ~(x & z);
            3'd1:    return ~x;
            3'd2:    return x & z;
            3'd3:    return x | z;
            3'd4:    return x ^ z;
            3'd5:    return ~(x | z);
            3'd6:    return ~(x ^ z);
            default: return z;
        endcase
    endfunction

    // Drives one cycle of inputs, advances the model over the edge, returns 1ns after it.
    task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input logic am, input logic ac, input logic ordy);
        logic [W-1:0] aEff;
        logic [W-1:0] r;
        bit acc;
        bit drn;
        lu.in_valid = iv; lu.a = ia; lu.b = ib; lu.op = iop;
        lu.acc_mode = am; lu.acc_clr = ac; lu.out_ready = ordy;
        acc  = iv && (modelQ.size() != 2);
        drn  = ordy && (modelQ.size() != 0);
        aEff = am ? (ac ? '0 : modelAcc) : ia;
        r    = refOp(iop, aEff, ib);
        @(posedge clk);
        if (drn) void'(modelQ.pop_front());
        if (acc) begin
            modelQ.push_back(r);
            modelOpCount = modelOpCount + 16'd1;
        end
        if (ac) modelAcc = '0;
        else if (acc && am) modelAcc = r;
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] ra;
        #12;
        checks++;
        if (lu.out_valid !== 1'b0 || lu.y !== '0 || lu.zero !== 1'b0 || lu.ones !== 1'b0 ||
            lu.op_count !== 16'd0 || lu.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_init got valid=%b y=%h zero=%b ones=%b cnt=%h rdy=%b want 0 0000 0 0 0000 1",
                     lu.out_valid, lu.y, lu.zero, lu.ones, lu.op_count, lu.in_ready);
        end
        rst_n = 1'b1;
        tick(1'b1, 16'($urandom), 16'h1234, 3'd7, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        checks++;
        if (lu.in_ready !== 1'b0 || lu.out_valid !== 1'b1 || lu.y !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL full_before_reset got rdy=%b valid=%b y=%h want 0 1 1234", lu.in_ready, lu.out_valid, lu.y);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (lu.out_valid !== 1'b0 || lu.y !== '0 || lu.zero !== 1'b0 || lu.ones !== 1'b0 ||
            lu.op_count !== 16'd0 || lu.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_midstream got valid=%b y=%h zero=%b ones=%b cnt=%h rdy=%b want 0 0000 0 0 0000 1",
                     lu.out_valid, lu.y, lu.zero, lu.ones, lu.op_count, lu.in_ready);
        end
        #1;
        rst_n = 1'b1;
        modelQ.delete();
        modelAcc = '0;
        modelOpCount = 16'd0;
        ra = 16'($urandom);
        tick(1'b1, ra, 16'($urandom), 3'd1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lu.y !== 16'hFFFF || lu.ones !== 1'b1 || lu.op_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL reset_acc got y=%h ones=%b cnt=%h want FFFF 1 0001", lu.y, lu.ones, lu.op_count);
        end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] expTab[8];
        expTab = '{16'h0FFF, 16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h000F, 16'hF00F, 16'hFF00};
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0, 1'b1);
            checks++;
            if (lu.out_valid !== 1'b1 || lu.y !== expTab[i] || lu.y !== modelQ[0]) begin
                errors++;
                $display("[TB] FAIL op_sweep op=%0d got valid=%b y=%h want 1 %h", i, lu.out_valid, lu.y, expTab[i]);
            end
        end
        tick(1'b1, 16'hFFFF, 16'($urandom), 3'd1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.y !== 16'h0000 || lu.zero !== 1'b1 || lu.ones !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_flag got y=%h zero=%b ones=%b want 0000 1 0", lu.y, lu.zero, lu.ones);
        end
        tick(1'b1, 16'hF0F0, 16'hFF00, 3'd3, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.y !== 16'hFFF0 || lu.zero !== 1'b0 || lu.ones !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ones_flag got y=%h zero=%b ones=%b want FFF0 0 0", lu.y, lu.zero, lu.ones);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ra[3];
        logic [W-1:0] rb[3];
        logic [2:0]   rop[3];
        logic [15:0]  base;
        tick(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty got valid=%b want 0", lu.out_valid);
        end
        base = modelOpCount;
        for (int i = 0; i < 3; i++) begin
            ra[i] = 16'($urandom); rb[i] = 16'($urandom); rop[i] = 3'($urandom);
            checks++;
            if (lu.in_ready !== (i < 2)) begin
                errors++;
                $display("[TB] FAIL bp_ready push=%0d got %b want %b", i, lu.in_ready, (i < 2));
            end
            tick(1'b1, ra[i], rb[i], rop[i], 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (lu.op_count !== base + 16'd2 || lu.in_ready !== 1'b0 || lu.y !== refOp(rop[0], ra[0], rb[0])) begin
            errors++;
            $display("[TB] FAIL bp_stall got cnt=%h rdy=%b y=%h want %h 0 %h", lu.op_count, lu.in_ready, lu.y,
                     base + 16'd2, refOp(rop[0], ra[0], rb[0]));
        end
        tick(1'b1, ra[2], rb[2], rop[2], 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.y !== refOp(rop[1], ra[1], rb[1]) || lu.op_count !== base + 16'd2 || lu.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_drain1 got y=%h cnt=%h rdy=%b want %h %h 1", lu.y, lu.op_count, lu.in_ready,
                     refOp(rop[1], ra[1], rb[1]), base + 16'd2);
        end
        tick(1'b1, ra[2], rb[2], rop[2], 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.y !== refOp(rop[2], ra[2], rb[2]) || lu.op_count !== base + 16'd3 || lu.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_third got y=%h cnt=%h valid=%b want %h %h 1", lu.y, lu.op_count, lu.out_valid,
                     refOp(rop[2], ra[2], rb[2]), base + 16'd3);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        tick(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        ra = 16'($urandom); rb = 16'($urandom);
        tick(1'b1, ra, rb, 3'd4, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.out_valid !== 1'b1 || lu.in_ready !== 1'b1 || lu.y !== (ra ^ rb)) begin
            errors++;
            $display("[TB] FAIL simul got valid=%b rdy=%b y=%h want 1 1 %h", lu.out_valid, lu.in_ready, lu.y, ra ^ rb);
        end
        tick(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_count got valid=%b want 0", lu.out_valid);
        end
    endtask

    task automatic test_accumulate();
        logic [W-1:0] bSeq[3];
        logic [W-1:0] ySeq[3];
        bSeq = '{16'h0001, 16'h0002, 16'h0004};
        ySeq = '{16'h0001, 16'h0003, 16'h0007};
        tick(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'($urandom), bSeq[i], 3'd4, 1'b1, 1'b0, 1'b1);
            checks++;
            if (lu.y !== ySeq[i] || lu.y !== modelQ[0]) begin
                errors++;
                $display("[TB] FAIL acc_step%0d got y=%h want %h", i, lu.y, ySeq[i]);
            end
        end
        tick(1'b1, 16'($urandom), 16'h00AA, 3'd3, 1'b1, 1'b1, 1'b1);
        checks++;
        if (lu.y !== 16'h00AA) begin
            errors++;
            $display("[TB] FAIL acc_clr_same got y=%h want 00AA", lu.y);
        end
        tick(1'b1, 16'($urandom), 16'($urandom), 3'd1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (lu.y !== 16'hFFFF || lu.ones !== 1'b1) begin
            errors++;
            $display("[TB] FAIL acc_after_clr got y=%h ones=%b want FFFF 1", lu.y, lu.ones);
        end
    endtask

    task automatic test_random();
        logic iv, am, ac, ordy;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(1, 0) != 0);
            am   = ($urandom_range(1, 0) != 0);
            ac   = ($urandom_range(7, 0) == 0);
            checks++;
            if (lu.in_ready !== (modelQ.size() != 2) || lu.out_valid !== (modelQ.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rand_hs n=%0d got rdy=%b valid=%b want %b %b", n, lu.in_ready, lu.out_valid,
                         (modelQ.size() != 2), (modelQ.size() != 0));
            end
            tick(iv, 16'($urandom), 16'($urandom), 3'($urandom), am, ac, ordy);
            checks++;
            if (lu.op_count !== modelOpCount ||
                (modelQ.size() != 0 && (lu.y !== modelQ[0] || lu.zero !== (modelQ[0] == '0) || lu.ones !== (&modelQ[0])))) begin
                errors++;
                $display("[TB] FAIL rand_data n=%0d got y=%h zero=%b ones=%b cnt=%h want y=%h cnt=%h", n, lu.y, lu.zero,
                         lu.ones, lu.op_count, (modelQ.size() != 0) ? modelQ[0] : '0, modelOpCount);
            end
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (modelOpCount != 16'hFFFE && guard < 70000) begin
            tick(1'b1, 16'($urandom), 16'($urandom), 3'd2, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        checks++;
        if (lu.op_count !== 16'hFFFE) begin
            errors++;
            $display("[TB] FAIL wrap_preload got cnt=%h want FFFE", lu.op_count);
        end
        tick(1'b1, 16'($urandom), 16'($urandom), 3'd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.op_count !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_max got cnt=%h want FFFF", lu.op_count);
        end
        tick(1'b1, 16'($urandom), 16'($urandom), 3'd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lu.op_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero got cnt=%h want 0000", lu.op_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lu.in_valid = 1'b0; lu.a = '0; lu.b = '0; lu.op = 3'd0;
        lu.acc_mode = 1'b0; lu.acc_clr = 1'b0; lu.out_ready = 1'b0;
        test_reset();
        test_op_sweep();
        test_backpressure();
        test_simultaneous();
        test_accumulate();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
